sigmoid_out_buffer: RTL and testbench

- Downstream stage of the sigmoid pipeline. Captures every valid result from the sigmoid core, which has no backpressure, into a DEPTH-entry FIFO.
- Presents the captured results to the consumer over a valid/ready handshake.
- Tracks samples launched into the sigmoid core but not yet returned (in flight). From that count it drives a credit signal (issue_ok) to the upstream launcher, so the FIFO can never overflow.

---
 rtl/sigmoid_out_buffer.sv | 106 ++++++++++
 tb/tb_sigmoid_out_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_out_buffer.sv
// Output buffer of the sigmoid pipeline: captures core results in a FIFO,
// drives them to the consumer over valid/ready and issues launch credits.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   issue/issue_ok  upstream launch strobe and launch credit
//   in_valid/data   sigmoid core output (no backpressure)
//   out_valid/ready/data  consumer handshake, data from FIFO head
//   count/inflight  stored entries / samples still inside the core
//   proto_err       sticky protocol-violation flag
module sigmoid_out_buffer #(
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 8,
   parameter int MAX_INFLIGHT = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue,
   output logic                              issue_ok,
   input  logic                              in_valid,
   input  logic [DATA_W-1:0]                 in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_W-1:0]                 out_data,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              proto_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(MAX_INFLIGHT+1);
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;

   logic          push;
   logic          pop;
   logic          full;
   logic          wr_en;
   logic          inc;
   logic          dec;
   logic          under;
   logic          over;
   logic          bad_issue;
   logic          err;
   logic [SW-1:0] load;

   always_comb begin
      push      = in_valid;
      out_valid = (count != '0);
      pop       = out_valid & out_ready;
      full      = (count == CW'(DEPTH));
      // At full a push still lands when the head leaves in the same cycle.
      wr_en     = push & (~full | pop);
      out_data  = mem[rd_ptr];
      load      = SW'(count) + SW'(inflight);
      issue_ok  = (load < SW'(DEPTH));
      inc       = issue & ~in_valid;
      dec       = in_valid & ~issue;
      under     = dec & (inflight == '0);
      over      = inc & (inflight == IW'(MAX_INFLIGHT));
      bad_issue = issue & ~issue_ok;
      err       = (push & ~wr_en) | under | over | bad_issue;
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         inflight  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !wr_en) begin
            count <= count - CW'(1);
         end
         // Underflow holds at zero, overflow saturates at the limit.
         if (inc && !over) begin
            inflight <= inflight + IW'(1);
         end else if (dec && !under) begin
            inflight <= inflight - IW'(1);
         end
         if (err) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sigmoid_out_buffer.sv
// Directed bench for sigmoid_out_buffer: reset, credit loop, drain order,
// push/pop at full, overflow and a credit-gated pointer-wrap stream.
module tb_sigmoid_out_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue;
   logic        issue_ok;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  count;
   logic [3:0]  inflight;
   logic        proto_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sigmoid_out_buffer #(
      .DATA_W(16),
      .DEPTH(8),
      .MAX_INFLIGHT(15)
   ) dut (
      .clk(clk),
      .rst(rst),
      .issue(issue),
      .issue_ok(issue_ok),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .inflight(inflight),
      .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      issue    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hdead;
      out_ready = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      idle();
   endtask

   // Fill 8 entries with issue and return in the same cycle (legal, no error).
   task automatic fill(input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         issue    = 1'b1;
         in_valid = 1'b1;
         in_data  = base + 16'(i);
         tick();
      end
      idle();
   endtask

   initial begin
      logic [3:0] pipe;
      int issued;
      int returned;
      int received;

      do_reset();
      chk("rst_count", 32'(count), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_issue_ok", 32'(issue_ok), 1);
      chk("rst_proto_err", 32'(proto_err), 0);

      // Credit loop: issue cycles 0..7, returns cycles 4..11.
      for (int t = 0; t < 12; t++) begin
         issue    = (t < 8);
         in_valid = (t >= 4);
         in_data  = (t >= 4) ? 16'(t - 4) : 16'h0;
         chk("credit_issue_ok", 32'(issue_ok), (t < 8) ? 1 : 0);
         tick();
         if (t == 5) begin
            chk("credit_mid_inflight", 32'(inflight), 4);
            chk("credit_mid_count", 32'(count), 2);
         end
      end
      idle();
      chk("credit_count", 32'(count), 8);
      chk("credit_inflight", 32'(inflight), 0);
      chk("credit_proto_err", 32'(proto_err), 0);
      chk("credit_issue_ok_full", 32'(issue_ok), 0);

      // Drain in order.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_data", 32'(out_data), i);
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(out_valid), 0);
      chk("drain_issue_ok", 32'(issue_ok), 1);
      chk("drain_count", 32'(count), 0);

      // Simultaneous push/pop at full. The push has no matching issue
      // (inflight==0), which flags proto_err, but the write must land.
      fill(16'h0010);
      chk("pp_fill_count", 32'(count), 8);
      chk("pp_fill_err", 32'(proto_err), 0);
      in_valid  = 1'b1;
      in_data   = 16'h3c00;
      out_ready = 1'b1;
      chk("pp_head", 32'(out_data), 16'h0010);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("pp_count", 32'(count), 8);
      chk("pp_underflow_err", 32'(proto_err), 1);
      out_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         chk("pp_drain", 32'(out_data), (i < 8) ? 32'h10 + i : 32'h3c00);
         tick();
      end
      out_ready = 1'b0;
      chk("pp_empty", 32'(out_valid), 0);

      // Overflow: push at full with no pop is dropped.
      do_reset();
      fill(16'h0020);
      chk("ovf_pre_err", 32'(proto_err), 0);
      in_valid = 1'b1;
      in_data  = 16'hbeef;
      tick();
      idle();
      chk("ovf_count", 32'(count), 8);
      chk("ovf_err", 32'(proto_err), 1);
      repeat (3) tick();
      chk("ovf_sticky", 32'(proto_err), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ovf_drain", 32'(out_data), 32'h20 + i);
         tick();
      end
      out_ready = 1'b0;
      chk("ovf_empty", 32'(out_valid), 0);
      chk("ovf_sticky2", 32'(proto_err), 1);

      // Pointer wrap: 20 samples through a 4-cycle core, credit-gated.
      do_reset();
      pipe     = '0;
      issued   = 0;
      returned = 0;
      received = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (received == 20) break;
         issue     = issue_ok && (issued < 20);
         in_valid  = pipe[3];
         in_data   = 16'h0100 + 16'(returned);
         out_ready = cyc[0];
         if (out_valid && out_ready) begin
            chk("wrap_data", 32'(out_data), 32'h100 + received);
            received++;
         end
         tick();
         if (issue) issued++;
         if (in_valid) returned++;
         pipe = {pipe[2:0], issue};
      end
      idle();
      chk("wrap_received", 32'(received), 20);
      chk("wrap_proto_err", 32'(proto_err), 0);
      chk("wrap_count", 32'(count), 0);
      chk("wrap_inflight", 32'(inflight), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
